// File: rtl/isqrt_pipe_arbiter.sv
// isqrt_pipe_arbiter: round-robin sharing of one fixed-latency pipelined
// integer square-root unit between N_REQ requesters. A valid/owner shift
// register tracks every in-flight operation so each result returns to the
// requester that issued it.
// Optional feature: define ISQRT_PIPE_ARBITER_ERR_CHECK_EN to compile in the
// sticky tracker/pipeline mismatch flag on err; otherwise err is tied to 0.
module isqrt_pipe_arbiter #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned W       = 32,
  parameter int unsigned LATENCY = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_vld,
  input  logic [N_REQ*W-1:0]       req_arg,
  output logic [N_REQ-1:0]         req_rdy,
  output logic [N_REQ-1:0]         res_vld,
  output logic [N_REQ*(W/2)-1:0]   res,
  output logic                     isqrt_x_vld,
  output logic [W-1:0]             isqrt_x,
  input  logic                     isqrt_y_vld,
  input  logic [W/2-1:0]           isqrt_y,
  output logic                     err
);

  localparam int unsigned IDW = $clog2(N_REQ);
  localparam int unsigned RW  = W / 2;

  logic [IDW-1:0] ptr;
  logic [IDW-1:0] gnt_id;
  logic           gnt_any;
  logic [IDW-1:0] issue_id;
  logic [IDW:0]   trk [LATENCY];
  logic           trk_vld;
  logic [IDW-1:0] trk_id;
  logic           hit;

  // Round-robin scan starting at ptr; first valid requester wins.
  always_comb begin
    req_rdy = '0;
    gnt_id  = '0;
    gnt_any = 1'b0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      logic [IDW-1:0] idx;
      idx = IDW'((32'(ptr) + k) % N_REQ);
      if (!gnt_any && req_vld[idx]) begin
        gnt_any = 1'b1;
        gnt_id  = idx;
      end
    end
    if (gnt_any) req_rdy[gnt_id] = 1'b1;
  end

  // Pointer advance past the granted requester and issue-stage register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr         <= '0;
      isqrt_x_vld <= 1'b0;
      isqrt_x     <= '0;
      issue_id    <= '0;
    end else begin
      isqrt_x_vld <= gnt_any;
      if (gnt_any) begin
        isqrt_x  <= req_arg[gnt_id*W +: W];
        issue_id <= gnt_id;
        if (gnt_id == IDW'(N_REQ - 1)) ptr <= '0;
        else                           ptr <= gnt_id + IDW'(1);
      end
    end
  end

  // Owner tracker: delays {valid, owner} so its tail lines up with isqrt_y_vld.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < LATENCY; i++) trk[i] <= '0;
    end else begin
      trk[0] <= {isqrt_x_vld, issue_id};
      for (int unsigned i = 1; i < LATENCY; i++) trk[i] <= trk[i-1];
    end
  end

  assign trk_vld = trk[LATENCY-1][IDW];
  assign trk_id  = trk[LATENCY-1][IDW-1:0];
  assign hit     = trk_vld & isqrt_y_vld;

  // Return stage: one-cycle result pulse to the owner; other slices hold.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      res_vld <= '0;
      res     <= '0;
    end else begin
      res_vld <= '0;
      if (hit) begin
        res_vld[trk_id]          <= 1'b1;
        res[trk_id*RW +: RW]     <= isqrt_y;
      end
    end
  end

`ifdef ISQRT_PIPE_ARBITER_ERR_CHECK_EN
  logic mismatch;
  assign mismatch = trk_vld ^ isqrt_y_vld;

  // Sticky error on any tracker/pipeline valid disagreement.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          err <= 1'b0;
    else if (mismatch) err <= 1'b1;
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_isqrt_pipe_arbiter.sv
// Directed bench for isqrt_pipe_arbiter with a behavioural isqrt pipeline.
module tb_isqrt_pipe_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned W  = 32;
  localparam int unsigned L  = 4;
  localparam int unsigned RW = 16;

`ifdef ISQRT_PIPE_ARBITER_ERR_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [N-1:0]      req_vld;
  logic [N*W-1:0]    req_arg;
  logic [N-1:0]      req_rdy;
  logic [N-1:0]      res_vld;
  logic [N*RW-1:0]   res;
  logic              isqrt_x_vld;
  logic [W-1:0]      isqrt_x;
  logic              isqrt_y_vld;
  logic [RW-1:0]     isqrt_y;
  logic              err;

  logic              mdl_vld [L];
  logic [RW-1:0]     mdl_y   [L];
  logic              inj;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  always #5 clk = ~clk;

  isqrt_pipe_arbiter #(.N_REQ(N), .W(W), .LATENCY(L)) dut (
    .clk(clk), .rst(rst),
    .req_vld(req_vld), .req_arg(req_arg), .req_rdy(req_rdy),
    .res_vld(res_vld), .res(res),
    .isqrt_x_vld(isqrt_x_vld), .isqrt_x(isqrt_x),
    .isqrt_y_vld(isqrt_y_vld), .isqrt_y(isqrt_y),
    .err(err)
  );

  function automatic logic [RW-1:0] sqrt_model(input logic [W-1:0] x);
    logic [31:0] r;
    logic [31:0] t;
    r = '0;
    for (int b = 15; b >= 0; b--) begin
      t = r | (32'd1 << b);
      if (t * t <= x) r = t;
    end
    return r[RW-1:0];
  endfunction

  // Shared isqrt pipeline stand-in, cleared with the block.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < L; i++) begin
        mdl_vld[i] <= 1'b0;
        mdl_y[i]   <= '0;
      end
    end else begin
      mdl_vld[0] <= isqrt_x_vld;
      mdl_y[0]   <= sqrt_model(isqrt_x);
      for (int i = 1; i < L; i++) begin
        mdl_vld[i] <= mdl_vld[i-1];
        mdl_y[i]   <= mdl_y[i-1];
      end
    end
  end

  assign isqrt_y_vld = mdl_vld[L-1] | inj;
  assign isqrt_y     = mdl_y[L-1];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst     = 1'b0;
    req_vld = '0;
    req_arg = '0;
    inj     = 1'b0;
    #1;
    check("rst_xvld", isqrt_x_vld, 0);
    check("rst_x", isqrt_x, 0);
    check("rst_resvld", res_vld, 0);
    check("rst_res", res, 0);
    check("rst_err", err, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    step();
  endtask

  initial begin : main
    logic [RW-1:0] exp_r [4];
    logic [N-1:0]  e;
    int            g;
    exp_r[0] = 16'd0; exp_r[1] = 16'd1; exp_r[2] = 16'hFFFF; exp_r[3] = 16'd1000;

    // Single request: 144 -> 12, result at cycle 6
    do_reset();
    req_arg[0 +: W] = 32'd144;
    req_vld = 4'b0001;
    #1 check("t1_rdy", req_rdy, 4'b0001);
    step();
    req_vld = '0;
    check("t1_xvld", isqrt_x_vld, 1);
    check("t1_x", isqrt_x, 144);
    for (int c = 2; c <= 7; c++) begin
      step();
      if (c == 2) begin
        check("t1_xvld_lo", isqrt_x_vld, 0);
        check("t1_x_hold", isqrt_x, 144);
      end
      check("t1_resvld", res_vld, (c == 6) ? 4'b0001 : 4'b0000);
      if (c == 6) check("t1_res0", res[0 +: RW], 12);
    end

    // All four valid: grants 0..3, results at cycles 6..9
    do_reset();
    req_arg[0*W +: W] = 32'd0;
    req_arg[1*W +: W] = 32'd1;
    req_arg[2*W +: W] = 32'hFFFF_FFFF;
    req_arg[3*W +: W] = 32'd1000000;
    req_vld = 4'b1111;
    for (int c = 0; c <= 11; c++) begin
      if (c >= 1 && c <= 4) req_vld[c-1] = 1'b0;
      #1;
      check("t2_rdy", req_rdy, (c < 4) ? (4'b0001 << c) : 4'b0000);
      e = (c >= 6 && c <= 9) ? (4'b0001 << (c - 6)) : 4'b0000;
      check("t2_resvld", res_vld, e);
      if (e != 0) check("t2_res", res[(c-6)*RW +: RW], exp_r[c-6]);
      step();
    end

    // Requesters 0 and 2 continuous: alternate grants and owners
    do_reset();
    req_arg[0*W +: W] = 32'd49;
    req_arg[2*W +: W] = 32'd400;
    for (int c = 0; c <= 15; c++) begin
      req_vld = (c < 8) ? 4'b0101 : 4'b0000;
      #1;
      check("t3_rdy", req_rdy, (c < 8) ? ((c % 2 == 0) ? 4'b0001 : 4'b0100) : 4'b0000);
      g = c - 6;
      e = (g >= 0 && g < 8) ? ((g % 2 == 0) ? 4'b0001 : 4'b0100) : 4'b0000;
      check("t3_resvld", res_vld, e);
      if (e == 4'b0001) check("t3_res0", res[0 +: RW], 7);
      if (e == 4'b0100) check("t3_res2", res[2*RW +: RW], 20);
      step();
    end

    // Reset with three operations in flight
    do_reset();
    req_arg[0*W +: W] = 32'd25;
    for (int c = 0; c <= 4; c++) begin
      req_vld = (c < 3) ? 4'b0001 : 4'b0000;
      step();
    end
    check("t4_pre_x", isqrt_x, 25);
    #2 rst = 1'b0;
    #1;
    check("t4_xvld", isqrt_x_vld, 0);
    check("t4_x", isqrt_x, 0);
    check("t4_resvld", res_vld, 0);
    check("t4_res", res, 0);
    check("t4_err", err, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    step();
    req_arg[3*W +: W] = 32'd81;
    req_vld = 4'b1000;
    #1;
    check("t4_rdy3", req_rdy, 4'b1000);
    check("t4_resvld_c0", res_vld, 0);
    step();
    req_vld = '0;
    for (int c = 1; c <= 8; c++) begin
      check("t4_resvld_c", res_vld, (c == 6) ? 4'b1000 : 4'b0000);
      if (c == 6) check("t4_res3", res[3*RW +: RW], 9);
      step();
    end

    // Spurious pipeline valid: dropped, err per build
    do_reset();
    check("t5_err_pre", err, 0);
    inj = 1'b1;
    step();
    inj = 1'b0;
    check("t5_resvld", res_vld, 0);
    for (int c = 1; c <= 4; c++) begin
      check("t5_err", err, EXP_ERR);
      step();
    end
    check("t5_resvld_after", res_vld, 0);
    do_reset();
    check("t5_err_clr", err, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/isqrt_pipe_arbiter.md
# isqrt_pipe_arbiter

Shares one fixed-latency pipelined integer square-root unit between `N_REQ` independent requesters. Each cycle at most one request is accepted, by round-robin arbitration, and issued into the shared pipeline. A valid/tag shift register tracks the owner of every in-flight operation, and each result is routed back to the requester that issued it. The block sits between the formula-evaluation front ends and a single `isqrt` pipeline instance, so several formula datapaths need only one pipelined root unit.

## Interface
- `N_REQ`, 4, number of requesters (2..8).
- `W`, 32, argument width; result width is `W/2`.
- `LATENCY`, 16, fixed `isqrt` pipeline latency in cycles, ≥1.
- `clk`  in  1  single clock; all state on rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `req_vld`  in  `N_REQ`  per-requester argument valid.
- `req_arg`  in  `N_REQ*W`  flattened arguments; requester i uses bits `[i*W +: W]`.
- `req_rdy`  out  `N_REQ`  grant; one-hot or zero; combinational.
- `res_vld`  out  `N_REQ`  per-requester result pulse; registered.
- `res`  out  `N_REQ*W/2`  flattened results; slice i is valid only when `res_vld[i]` is high.
- `isqrt_x_vld`  out  1  issue valid to the shared pipeline; registered.
- `isqrt_x`  out  `W`  issued argument.
- `isqrt_y_vld`  in  1  result valid from the pipeline.
- `isqrt_y`  in  `W/2`  result from the pipeline.
- `err`  out  1  sticky tag-tracking error (see Configuration).

## Operation
- Round-robin pointer `ptr` (`$clog2(N_REQ)` bits) marks the highest-priority requester.
- `req_rdy[i]` is high for the first i with `req_vld[i]` high, scanning `ptr, ptr+1, …` modulo `N_REQ`.
- A transfer happens when `req_vld[i] & req_rdy[i]`. On a transfer to requester i, `ptr` becomes `(i+1) mod N_REQ`. With no transfer, `ptr` holds.
- `req_rdy` never depends on `isqrt_y_vld`. The shared pipeline does not stall, so there is no backpressure.
- Issue stage:
  - On a transfer, the next cycle drives `isqrt_x_vld=1` and `isqrt_x` = the granted argument.
  - Otherwise `isqrt_x_vld=0` and `isqrt_x` holds its previous value.
- Tag tracker:
  - Shift register of depth `LATENCY`, width `1 + $clog2(N_REQ)` bits (valid + owner id).
  - Loaded with `{isqrt_x_vld, owner}` every cycle and shifted every cycle.
  - Its output aligns with `isqrt_y_vld`.
- Return stage: when the tracker output is valid and `isqrt_y_vld=1`, then one cycle later `res_vld[owner]=1` and the `owner` slice of `res` = `isqrt_y`. All other `res_vld` bits are 0.
- The `res` slices of other requesters hold their previous values.
- Requesters must hold `req_arg` stable while `req_vld` is high and `req_rdy` is low.
- Reset (asynchronous, any time): `ptr=0`, `isqrt_x_vld=0`, `isqrt_x=0`, tracker cleared, `res_vld=0`, `res=0`, `err=0`.
- Operations in flight at reset are lost; no `res_vld` is produced for them.

## Timing
- Request accepted at cycle t → `isqrt_x_vld` at t+1 → `isqrt_y_vld` at t+1+`LATENCY` → `res_vld` at t+2+`LATENCY`.
- Total latency is `LATENCY+2` cycles.
- Throughput is one accepted request per cycle across all requesters.
- A single continuously requesting requester is granted every cycle.
- Results return in issue order. Back-to-back results to the same requester produce consecutive `res_vld` pulses.
- Tracker output valid with `isqrt_y_vld=0`, or `isqrt_y_vld=1` with tracker output invalid, is a mismatch.
  - The result is dropped: no `res_vld`.
  - Error reporting follows Configuration.

## Configuration
- `ISQRT_PIPE_ARBITER_ERR_CHECK_EN` defined:
  - Any mismatch sets `err=1` on the next cycle.
  - `err` stays 1 until reset.
- Macro not defined:
  - No mismatch logic is compiled in; `err` is tied to 0.
  - Mismatched results are still dropped.

## Test plan
Bench settings: `N_REQ=4`, `W=32`, `LATENCY=4`; the bench models the `isqrt` pipeline.
- Single request, `req_vld[0]=1`, arg 144, accepted at cycle 0 → `isqrt_x_vld` at cycle 1; `res_vld=4'b0001` with `res[0]=12` at cycle 6 only.
- All four requesters valid at cycle 0 with args 0, 1, 0xFFFFFFFF, 1000000 (held until accepted) → grants 0,1,2,3 on cycles 0–3. Results are `res[0]=0` at cycle 6, `res[1]=1` at 7, `res[2]=0xFFFF` at 8, `res[3]=1000` at 9.
- Requesters 0 and 2 valid continuously → grant sequence 0,2,0,2,…; requesters 1 and 3 never granted; each result goes only to its owner.
- Reset asserted 2 cycles after three issues → all outputs 0 immediately. After release, no `res_vld` from the lost operations. A new request from requester 3 is granted at once (`ptr=0`, only requester valid).
- Checker build: bench injects `isqrt_y_vld=1` with nothing issued → no `res_vld`; `err=1` the next cycle, held until reset. Non-checker build: `err` stays 0.
